// File: rtl/angular_filter_accum.sv
// Intra-angular prediction accumulator: sums four signed MCM products, rounds,
// shifts and clips to an unsigned sample through a 3-register valid/ready pipeline.
module angular_filter_accum #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6,
  parameter int BLK_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          p0,
  input  logic [IN_W-1:0]          p1,
  input  logic [IN_W-1:0]          p2,
  input  logic [IN_W-1:0]          p3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sample,
  output logic [$clog2(BLK_W)-1:0] out_idx,
  output logic                     out_last
);

  localparam int IDX_W = $clog2(BLK_W);
  localparam int SW    = IN_W + 3;
  localparam logic signed [SW-1:0] RND_C  = SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] MAX_C  = SW'((1 << OUT_W) - 1);
  localparam logic [IDX_W-1:0]     LAST_C = IDX_W'(BLK_W - 1);

  // One extra bit of headroom so the rounding offset cannot overflow the sum.
  function automatic logic [OUT_W-1:0] round_clip(input logic signed [IN_W+1:0] sum);
    logic signed [SW-1:0] r;
    r = ($signed({sum[IN_W+1], sum}) + RND_C) >>> SHIFT;
    if (r[SW-1]) begin
      round_clip = {OUT_W{1'b0}};
    end else if (r > MAX_C) begin
      round_clip = {OUT_W{1'b1}};
    end else begin
      round_clip = r[OUT_W-1:0];
    end
  endfunction

  logic                    v_s1_r, v_s2_r, v_out_r;
  logic signed [IN_W:0]    s01_r, s23_r;
  logic [OUT_W-1:0]        sample_s2_r, out_sample_r;
  logic [IDX_W-1:0]        out_idx_r;
  logic                    out_last_r;

  logic                    ld_out_s, drain_s, ld_s2_s, in_ready_s, accept_s;
  logic signed [IN_W:0]    s01_s, s23_s;
  logic signed [IN_W+1:0]  sum_s;
  logic [IDX_W-1:0]        idx_nxt_s;

  // Handshake: each stage loads when empty or when its successor moves on this cycle.
  always_comb begin
    drain_s    = v_out_r && out_ready;
    ld_out_s   = v_s2_r && (!v_out_r || out_ready);
    ld_s2_s    = v_s1_r && (!v_s2_r || ld_out_s);
    in_ready_s = !v_s1_r || ld_s2_s;
    accept_s   = in_valid && in_ready_s;
    s01_s      = $signed({p0[IN_W-1], p0}) + $signed({p1[IN_W-1], p1});
    s23_s      = $signed({p2[IN_W-1], p2}) + $signed({p3[IN_W-1], p3});
    sum_s      = $signed({s01_r[IN_W], s01_r}) + $signed({s23_r[IN_W], s23_r});
    if (out_idx_r == LAST_C) begin
      idx_nxt_s = {IDX_W{1'b0}};
    end else begin
      idx_nxt_s = out_idx_r + IDX_W'(1);
    end
  end

  // Pipeline registers and row index counter; flush clears exactly like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s1_r       <= 1'b0;
      v_s2_r       <= 1'b0;
      v_out_r      <= 1'b0;
      s01_r        <= '0;
      s23_r        <= '0;
      sample_s2_r  <= '0;
      out_sample_r <= '0;
      out_idx_r    <= '0;
      out_last_r   <= 1'b0;
    end else if (flush) begin
      v_s1_r       <= 1'b0;
      v_s2_r       <= 1'b0;
      v_out_r      <= 1'b0;
      s01_r        <= '0;
      s23_r        <= '0;
      sample_s2_r  <= '0;
      out_sample_r <= '0;
      out_idx_r    <= '0;
      out_last_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        v_s1_r <= 1'b1;
        s01_r  <= s01_s;
        s23_r  <= s23_s;
      end else if (ld_s2_s) begin
        v_s1_r <= 1'b0;
      end

      if (ld_s2_s) begin
        v_s2_r      <= 1'b1;
        sample_s2_r <= round_clip(sum_s);
      end else if (ld_out_s) begin
        v_s2_r <= 1'b0;
      end

      if (ld_out_s) begin
        v_out_r      <= 1'b1;
        out_sample_r <= sample_s2_r;
      end else if (drain_s) begin
        v_out_r <= 1'b0;
      end

      // Index tracks the presented sample, so it advances with the transfer itself.
      if (drain_s) begin
        out_idx_r  <= idx_nxt_s;
        out_last_r <= (idx_nxt_s == LAST_C);
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = v_out_r;
  assign out_sample = out_sample_r;
  assign out_idx    = out_idx_r;
  assign out_last   = out_last_r;

endmodule

// File: tb/tb_angular_filter_accum.sv
// Directed bench for angular_filter_accum: latency, rounding/clipping, backpressure,
// row index wrap, async reset and flush, against hand-computed expectations.
module tb_angular_filter_accum;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p0, p1, p2, p3;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sample;
  logic [3:0]  out_idx;
  logic        out_last;

  int total;
  int bad;

  angular_filter_accum #(.IN_W(16), .OUT_W(8), .SHIFT(6), .BLK_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_idx(out_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // p0 = 64*v with the rest zero yields exactly v after rounding and shift.
  task automatic drive_val(input int v);
    p0 = 16'(64 * v);
    p1 = 16'd0;
    p2 = 16'd0;
    p3 = 16'd0;
  endtask

  initial begin
    int vals [5];
    int k;
    int n;
    logic acc;
    vals = '{10, 20, 30, 40, 50};
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    p0 = 16'd0; p1 = 16'd0; p2 = 16'd0; p3 = 16'd0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic sample: 11900 + 32 >> 6 = 186, visible after the third edge counting the accept.
    p0 = 16'd5300; p1 = 16'd1800; p2 = 16'd2800; p3 = 16'd2000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat2_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sample", 32'(out_sample), 32'd186);
    check("t1_idx", 32'(out_idx), 32'd0);
    check("t1_last", 32'(out_last), 32'd0);
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);
    check("t1_idx_adv", 32'(out_idx), 32'd1);

    // Clip: -2000 -> r=-31 -> 0; 4*16000 -> r=1000 -> 255.
    p0 = 16'(-2000); p1 = 16'd0; p2 = 16'd0; p3 = 16'd0;
    in_valid = 1'b1;
    tick();
    p0 = 16'd16000; p1 = 16'd16000; p2 = 16'd16000; p3 = 16'd16000;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_lo_valid", 32'(out_valid), 32'd1);
    check("t2_lo_sample", 32'(out_sample), 32'd0);
    check("t2_lo_idx", 32'(out_idx), 32'd1);
    tick();
    check("t2_hi_valid", 32'(out_valid), 32'd1);
    check("t2_hi_sample", 32'(out_sample), 32'd255);
    check("t2_hi_idx", 32'(out_idx), 32'd2);
    tick();
    check("t2_empty", 32'(out_valid), 32'd0);

    // Backpressure: six stalled cycles with five offered samples fill exactly three stages.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      drive_val(vals[k]);
      #1;
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    check("t3_accepted", 32'(k), 32'd3);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_hold_valid", 32'(out_valid), 32'd1);
    check("t3_hold_sample", 32'(out_sample), 32'd10);
    check("t3_hold_idx", 32'(out_idx), 32'd3);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (k < 5) begin
        in_valid = 1'b1;
        drive_val(vals[k]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check("t3_order_sample", 32'(out_sample), 32'(vals[n]));
        check("t3_order_idx", 32'(out_idx), 32'(3 + n));
        n++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("t3_out_count", 32'(n), 32'd5);

    // Flush with two samples in flight and a third offered on the flush cycle.
    in_valid = 1'b1;
    drive_val(77);
    tick();
    drive_val(88);
    tick();
    drive_val(99);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_idx", 32'(out_idx), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_output", 32'(out_valid), 32'd0);
    end

    // Seventeen back-to-back samples: last only on the 16th, 17th wraps to index 0.
    n = 0;
    k = 0;
    for (int c = 0; c < 30 && n < 17; c++) begin
      if (k < 17) begin
        in_valid = 1'b1;
        drive_val(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check("t4_sample", 32'(out_sample), 32'(n + 1));
        check("t4_idx", 32'(out_idx), 32'(n % 16));
        check("t4_last", 32'(out_last), (n == 15) ? 32'd1 : 32'd0);
        n++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("t4_out_count", 32'(n), 32'd17);

    // Async reset with a full, stalled pipeline.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_val(7);
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("t5_full_valid", 32'(out_valid), 32'd1);
    check("t5_full_idx", 32'(out_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_idx", 32'(out_idx), 32'd0);
    check("t5_async_last", 32'(out_last), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive_val(5);
    tick();
    in_valid = 1'b0;
    check("t5_post_lat1", 32'(out_valid), 32'd0);
    tick();
    check("t5_post_lat2", 32'(out_valid), 32'd0);
    tick();
    check("t5_post_valid", 32'(out_valid), 32'd1);
    check("t5_post_sample", 32'(out_sample), 32'd5);
    check("t5_post_idx", 32'(out_idx), 32'd0);
    tick();
    check("t5_post_drained", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
